mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 256x8 synchronous memory between the CPU instruction-fetch port and
//  the load/store data port. Sits between the fetch/LSU logic and the memory instance.
//  Owns the memory write enable, address and write data. Runs a 3-state FSM, one transaction at a time.
// PARAMETERS
//  ADDR_W  8  address width; the memory is 2**ADDR_W deep
//  DATA_W  8  data width
// PORTS
//  clk            in   1       system clock; all state updates on posedge
//  reset          in   1       synchronous, active-high reset
//  inst_req       in   1       fetch request; held until inst_ready
//  inst_addr      in   ADDR_W  fetch address; stable while inst_req
//  inst_ready     out  1       1-cycle pulse; inst_rdata valid this cycle
//  inst_rdata     out  DATA_W  fetched byte
//  data_req       in   1       load/store request; held until data_ready
//  data_we        in   1       1=store, 0=load; stable while data_req
//  data_addr      in   ADDR_W  load/store address
//  data_wdata     in   DATA_W  store data
//  data_ready     out  1       1-cycle pulse; load data valid, or store done
//  data_rdata     out  DATA_W  loaded byte
//  mem_memwrite   out  1       memory write enable
//  mem_addr       out  ADDR_W  memory address
//  mem_data_in    out  DATA_W  memory write data
//  mem_data_out   in   DATA_W  memory read data; registered, valid 1 cycle after address sampled
//  busy           out  1       high in BUSY and RESP
// BEHAVIOUR
//  Reset: state=IDLE, owner=INST, rr_last=DATA; every output 0. A reset mid-transaction aborts
//   it with no ready pulse. mem_memwrite is 0 from the cycle after the reset edge.
//  IDLE: if either req is high, pick an owner. Register the owner's addr, we and wdata into
//   mem_addr, mem_memwrite (=owner is DATA && data_we) and mem_data_in, then go to BUSY.
//   With no req, stay in IDLE and hold mem_memwrite=0.
//  BUSY: the memory samples mem_* at the closing edge; clear mem_memwrite; go to RESP.
//  RESP: pulse the owner's ready for exactly 1 cycle. Drive its rdata = mem_data_out (stores
//   return the old byte; the requester ignores it). The other ready stays 0. Go to IDLE.
//  Latency: req first seen in IDLE at cycle N -> ready at cycle N+2. Throughput: 1 access per 3 cycles.
//  Handshake: a req still high in the IDLE cycle after ready starts a new transaction.
//   Requesters drop req in the cycle after ready unless they want a back-to-back access.
//   Changing addr/we/wdata while req is high is illegal; the arbiter uses the values latched in IDLE.
//  Conflict (both req in IDLE): the default is fixed priority, DATA wins.
//   Fetch waits, so an in-flight load/store always completes first.
//  A req arriving in BUSY/RESP is not sampled until the next IDLE. There are no outstanding queues.
//  Addresses are passed through unmodified; no wrap or range checks; 8'hFF is a legal address.
//  rdata outputs hold their last value outside RESP.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin on conflict. The grant goes to the requester not in rr_last.
//   rr_last updates on every grant, including uncontested grants. Neither port can starve.
//  MEM_ARB_RR_EN undefined: fixed DATA>INST priority and no rr_last register.
//   Sustained data_req starves fetch; the CPU guarantees this does not happen.
// STRUCTURE
//  mem_arb_pkg: localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2; OWN_INST=1'b0, OWN_DATA=1'b1.
//  mem_arb_pick: combinational sub-module (inst_req, data_req, rr_last -> grant_valid, grant_owner).
//   It contains the MEM_ARB_RR_EN conditional. The FSM and output registers stay in mem_arbiter.
// TESTING
//  1 Reset, then idle 5 cycles -> all outputs 0, busy=0, mem_memwrite never 1.
//  2 data_req=1 we=1 addr=8'h10 wdata=8'hA5 -> mem_memwrite=1 for exactly 1 cycle, data_ready at N+2.
//    Then a load from 8'h10 -> data_rdata=8'hA5.
//  3 Preload 8'h20=8'h3C; inst_req addr=8'h20 -> inst_ready at N+2 with inst_rdata=8'h3C;
//    data_ready stays 0 throughout.
//  4 Both req in the same cycle (inst 8'h00, data load 8'h01), held high -> data served first,
//    then inst. With MEM_ARB_RR_EN, 4 back-to-back conflicts alternate D,I,D,I.
//  5 Store issued, reset asserted during BUSY -> no data_ready; next cycle all outputs 0, state IDLE.
//  6 inst_req held high continuously at addr=8'hFF -> inst_ready every 3rd cycle with the correct byte.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose: shared state encoding and owner codes for the memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state localparams and enum, owner identifiers (INST=0, DATA=1).
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_BUSY = ST_BUSY,
      S_RESP = ST_RESP
   } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational grant picker between fetch and load/store requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: inst_req/data_req in, rr_last in (only when MEM_ARB_RR_EN is defined),
//        grant_valid/grant_owner out.
// Config: MEM_ARB_RR_EN defined -> round-robin on conflict; undefined -> DATA beats INST.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
`ifdef MEM_ARB_RR_EN
   input  logic rr_last,
`endif
   output logic grant_valid,
   output logic grant_owner
);

   always_comb begin
      grant_valid = inst_req | data_req;
      grant_owner = OWN_INST;
`ifdef MEM_ARB_RR_EN
      // On a conflict the port that did not win last time gets the grant.
      if (inst_req && data_req) begin
         grant_owner = ~rr_last;
      end else if (data_req) begin
         grant_owner = OWN_DATA;
      end
`else
      // Fixed priority: a pending load/store always beats a fetch.
      if (data_req) begin
         grant_owner = OWN_DATA;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port synchronous memory between fetch and load/store ports.
// Latency: request seen in IDLE at cycle N -> ready pulse at N+2; one access per 3 cycles.
// Backpressure: requesters hold req until their ready pulse; no queueing, one transaction at a time.
// Ports: clk, reset (sync, active-high); inst_req/inst_addr -> inst_ready/inst_rdata;
//        data_req/data_we/data_addr/data_wdata -> data_ready/data_rdata;
//        mem_memwrite/mem_addr/mem_data_in -> memory, mem_data_out <- memory; busy.
// Config: MEM_ARB_RR_EN defined adds an rr_last register and round-robin conflict arbitration.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_ready,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_ready,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_memwrite,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_memwrite_q, mem_memwrite_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              grant_valid;
   logic              grant_owner;
`ifdef MEM_ARB_RR_EN
   logic              rr_last_q, rr_last_d;
`endif

   mem_arb_pick u_pick (
      .inst_req    (inst_req),
      .data_req    (data_req),
`ifdef MEM_ARB_RR_EN
      .rr_last     (rr_last_q),
`endif
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      mem_addr_d     = mem_addr_q;
      // Write enable is only ever high for the single BUSY cycle.
      mem_memwrite_d = 1'b0;
      mem_data_in_d  = mem_data_in_q;
      inst_rdata_d   = inst_rdata_q;
      data_rdata_d   = data_rdata_q;
`ifdef MEM_ARB_RR_EN
      rr_last_d      = rr_last_q;
`endif
      inst_ready     = 1'b0;
      data_ready     = 1'b0;
      inst_rdata     = inst_rdata_q;
      data_rdata     = data_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               owner_d = grant_owner;
`ifdef MEM_ARB_RR_EN
               rr_last_d = grant_owner;
`endif
               state_d = S_BUSY;
               if (grant_owner == OWN_DATA) begin
                  mem_addr_d     = data_addr;
                  mem_memwrite_d = data_we;
                  mem_data_in_d  = data_wdata;
               end else begin
                  mem_addr_d     = inst_addr;
               end
            end
         end
         S_BUSY: begin
            // Memory samples mem_* at the edge closing this cycle.
            state_d = S_RESP;
         end
         S_RESP: begin
            // Registered memory output is valid now; pass it straight through
            // and keep a copy so rdata holds until the next response.
            state_d = S_IDLE;
            if (owner_q == OWN_DATA) begin
               data_ready   = 1'b1;
               data_rdata   = mem_data_out;
               data_rdata_d = mem_data_out;
            end else begin
               inst_ready   = 1'b1;
               inst_rdata   = mem_data_out;
               inst_rdata_d = mem_data_out;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         owner_q        <= OWN_INST;
         mem_addr_q     <= '0;
         mem_memwrite_q <= 1'b0;
         mem_data_in_q  <= '0;
         inst_rdata_q   <= '0;
         data_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
         rr_last_q      <= OWN_DATA;
`endif
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         mem_addr_q     <= mem_addr_d;
         mem_memwrite_q <= mem_memwrite_d;
         mem_data_in_q  <= mem_data_in_d;
         inst_rdata_q   <= inst_rdata_d;
         data_rdata_q   <= data_rdata_d;
`ifdef MEM_ARB_RR_EN
         rr_last_q      <= rr_last_d;
`endif
      end
   end

   assign mem_addr     = mem_addr_q;
   assign mem_memwrite = mem_memwrite_q;
   assign mem_data_in  = mem_data_in_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter with a behavioural memory and reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       inst_req;
   logic [7:0] inst_addr;
   logic       inst_ready;
   logic [7:0] inst_rdata;
   logic       data_req;
   logic       data_we;
   logic [7:0] data_addr;
   logic [7:0] data_wdata;
   logic       data_ready;
   logic [7:0] data_rdata;
   logic       mem_memwrite;
   logic [7:0] mem_addr;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out;
   logic       busy;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_ready   (inst_ready),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_we      (data_we),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_ready   (data_ready),
      .data_rdata   (data_rdata),
      .mem_memwrite (mem_memwrite),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .busy         (busy)
   );

   // 256x8 synchronous single-port memory; read returns the pre-write byte.
   logic [7:0] mem [0:255];
   logic       pl_en;
   logic [7:0] pl_addr;
   logic [7:0] pl_dat;
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_dat;
      else if (mem_memwrite) mem[mem_addr] <= mem_data_in;
      mem_data_out <= mem[mem_addr];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: memory contents and last granted owner.
   logic [7:0] ref_mem [0:255];
   logic       m_rr;

   function automatic logic ref_pick(input logic i, input logic d, input logic rr);
      if (i && d) return RR_EN ? ~rr : OWN_DATA;
      return d ? OWN_DATA : OWN_INST;
   endfunction

   typedef struct {
      bit         i_en;
      bit         d_en;
      bit         d_we;
      logic [7:0] i_addr;
      logic [7:0] d_addr;
      logic [7:0] wdata;
      bit         first_data;
      logic [7:0] exp_i;
      logic [7:0] exp_d;
   } vec_t;

   // Serve the requests in grant order, reading then updating the model memory.
   task automatic model_pair(input vec_t v, output bit first_data,
                             output logic [7:0] exp_i, output logic [7:0] exp_d);
      bit sd;
      first_data = (ref_pick(v.i_en, v.d_en, m_rr) == OWN_DATA);
      exp_i = 8'h00;
      exp_d = 8'h00;
      for (int k = 0; k < 2; k++) begin
         sd = (k == 0) ? first_data : !first_data;
         if (sd && v.d_en) begin
            exp_d = ref_mem[v.d_addr];
            if (v.d_we) ref_mem[v.d_addr] = v.wdata;
            m_rr = OWN_DATA;
         end else if (!sd && v.i_en) begin
            exp_i = ref_mem[v.i_addr];
            m_rr = OWN_INST;
         end
      end
   endtask

   // Drive one or two simultaneous requests from IDLE and check the responses.
   task automatic run_pair(input vec_t v, input bit first_data, input logic [7:0] exp_i,
                           input logic [7:0] exp_d, input string tag);
      int cyc, lat_i, lat_d, wr_cnt;
      bit got_i, got_d, spurious, wr_ok;
      logic [7:0] rd_i, rd_d;
      @(negedge clk);
      inst_req   = v.i_en;
      inst_addr  = v.i_addr;
      data_req   = v.d_en;
      data_we    = v.d_we;
      data_addr  = v.d_addr;
      data_wdata = v.wdata;
      got_i = !v.i_en; got_d = !v.d_en;
      lat_i = -1; lat_d = -1; cyc = 0; wr_cnt = 0; spurious = 0; wr_ok = 1;
      rd_i = 8'hxx; rd_d = 8'hxx;
      while (!(got_i && got_d) && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (mem_memwrite) begin
            wr_cnt++;
            if (mem_addr !== v.d_addr || mem_data_in !== v.wdata) wr_ok = 0;
         end
         if (inst_ready) begin
            if (got_i) spurious = 1;
            else begin got_i = 1; lat_i = cyc; rd_i = inst_rdata; inst_req = 1'b0; end
         end
         if (data_ready) begin
            if (got_d) spurious = 1;
            else begin got_d = 1; lat_d = cyc; rd_d = data_rdata; data_req = 1'b0; end
         end
      end
      if (v.i_en) begin
         check({tag, "_lat_i"}, 64'(lat_i), 64'(first_data ? 5 : 2));
         check({tag, "_rdata_i"}, 64'(rd_i), 64'(exp_i));
      end
      if (v.d_en) begin
         check({tag, "_lat_d"}, 64'(lat_d), 64'(first_data ? 2 : 5));
         check({tag, "_rdata_d"}, 64'(rd_d), 64'(exp_d));
      end
      check({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(v.d_en && v.d_we));
      if (v.d_en && v.d_we) check({tag, "_wr_bus"}, 64'(wr_ok), 64'd1);
      check({tag, "_spurious"}, 64'(spurious), 64'd0);
      // Following IDLE cycle: no ready, not busy, rdata held.
      @(negedge clk);
      check({tag, "_idle"}, 64'({inst_ready, data_ready, busy}), 64'd0);
      if (v.i_en) check({tag, "_hold_i"}, 64'(inst_rdata), 64'(rd_i));
      if (v.d_en) check({tag, "_hold_d"}, 64'(data_rdata), 64'(rd_d));
   endtask

   vec_t tbl [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      vec_t v;
      bit mf;
      logic [7:0] mi, md;
      int last, n_rdy, k;
      bit spur;

      // {i_en, d_en, d_we, i_addr, d_addr, wdata, first_data, exp_i, exp_d}
      tbl[0] = '{0, 1, 1, 8'h00, 8'h10, 8'hA5, 1, 8'h00, 8'h00}; // store 10<=A5, old byte 00
      tbl[1] = '{0, 1, 0, 8'h00, 8'h10, 8'h00, 1, 8'h00, 8'hA5}; // load 10
      tbl[2] = '{1, 0, 0, 8'h20, 8'h00, 8'h00, 0, 8'h3C, 8'h00}; // fetch preloaded 20
      tbl[3] = '{1, 1, 0, 8'h00, 8'h01, 8'h00, 1, 8'h11, 8'h22}; // conflict, data first
      tbl[4] = '{1, 1, 1, 8'h10, 8'h40, 8'h99, 1, 8'hA5, 8'h00}; // conflict with store
      tbl[5] = '{1, 1, 0, 8'h40, 8'hFF, 8'h00, 1, 8'h99, 8'h5A}; // fetch stored byte, load FF

      reset = 1'b1; inst_req = 1'b0; inst_addr = 8'h00; data_req = 1'b0; data_we = 1'b0;
      data_addr = 8'h00; data_wdata = 8'h00;
      pl_en = 1'b1; pl_addr = 8'h00; pl_dat = 8'h00;

      // Clear memory while reset is held, then preload a few bytes.
      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         pl_addr = 8'(a); pl_dat = 8'h00;
         ref_mem[a] = 8'h00;
      end
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         case (p)
            0: begin pl_addr = 8'h20; pl_dat = 8'h3C; end
            1: begin pl_addr = 8'h00; pl_dat = 8'h11; end
            2: begin pl_addr = 8'h01; pl_dat = 8'h22; end
            default: begin pl_addr = 8'hFF; pl_dat = 8'h5A; end
         endcase
         ref_mem[pl_addr] = pl_dat;
      end
      @(negedge clk);
      pl_en = 1'b0;
      reset = 1'b0;
      m_rr  = OWN_DATA;

      // Reset state held through 5 idle cycles.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("reset_idle%0d", c),
               64'({inst_ready, data_ready, busy, mem_memwrite, mem_addr, mem_data_in,
                    inst_rdata, data_rdata}), 64'd0);
      end

      // Directed vectors.
      for (int i = 0; i < 6; i++) begin
         model_pair(tbl[i], mf, mi, md);
         run_pair(tbl[i], RR_EN ? mf : tbl[i].first_data, tbl[i].exp_i, tbl[i].exp_d,
                  $sformatf("vec%0d", i));
      end

      // Reset during BUSY aborts the store with no ready pulse.
      @(negedge clk);
      data_req = 1'b1; data_we = 1'b1; data_addr = 8'h30; data_wdata = 8'h77;
      @(negedge clk);
      check("abort_busy", 64'({busy, mem_memwrite}), 64'd3);
      reset = 1'b1; data_req = 1'b0;
      @(negedge clk);
      check("abort_outputs",
            64'({inst_ready, data_ready, busy, mem_memwrite, mem_addr, mem_data_in,
                 inst_rdata, data_rdata}), 64'd0);
      reset = 1'b0;
      // The memory still saw the write enable on the closing BUSY edge.
      ref_mem[8'h30] = 8'h77;
      m_rr = OWN_DATA;

      // Randomized traffic against the model.
      for (int r = 0; r < 40; r++) begin
         k = $urandom_range(1, 3);
         v.i_en   = k[0];
         v.d_en   = k[1];
         v.d_we   = 1'($urandom_range(0, 1));
         v.i_addr = 8'($urandom_range(0, 15));
         v.d_addr = 8'($urandom_range(0, 15));
         v.wdata  = 8'($urandom);
         v.first_data = 1'b0; v.exp_i = 8'h00; v.exp_d = 8'h00;
         model_pair(v, mf, mi, md);
         run_pair(v, mf, mi, md, $sformatf("rnd%0d", r));
      end

      // Fetch held continuously at the top address: one ready every 3 cycles.
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 8'hFF;
      last = 0; n_rdy = 0; spur = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (data_ready) spur = 1;
         if (inst_ready) begin
            n_rdy++;
            check($sformatf("stream_rdata%0d", n_rdy), 64'(inst_rdata), 64'(ref_mem[8'hFF]));
            check($sformatf("stream_gap%0d", n_rdy), 64'(c - last), 64'(last == 0 ? 2 : 3));
            last = c;
         end
      end
      inst_req = 1'b0;
      check("stream_count", 64'(n_rdy), 64'd4);
      check("stream_no_data", 64'(spur), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
